alu_mux_arbiter: RTL

Round-robin arbiter that shares one 8-bit ALU between four requesters. It drives the 2-bit select of the 4:1 operand muxes (one mux per operand bit) and starts the ALU. It waits for the ALU's completion handshake, then returns a one-cycle done pulse to the winning requester. It sits between the four requester ports and the mux/ALU datapath.

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/alu_mux_arbiter_rr_pick_4.sv | 32 +++
 rtl/alu_mux_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU round-robin arbiter.
// Holds the requester count, the select width, the FSM state encoding
// and the index-to-one-hot helper used for grant and done vectors.
package alu_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    // Binary 2-bit state encoding
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Turn a requester index into a one-hot requester vector
    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_mux_arbiter_rr_pick_4.sv
// Combinational 4-way round-robin picker.
// Scans ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first requester
// found. When nothing is requesting, any=0 and win just echoes ptr.
module rr_pick_4
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] cand [NREQ];
    logic [NREQ-1:0]  hit;

    // cand[k] is the requester visited at scan step k, hit[k] its request
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = ptr + SEL_W'(gi + 1);
        assign hit[gi]  = req[cand[gi]];
    end

    // Earliest scan step with a request wins
    always_comb begin
        win = ptr;
        any = |hit;
        if (hit[0])      win = cand[0];
        else if (hit[1]) win = cand[1];
        else if (hit[2]) win = cand[2];
        else if (hit[3]) win = cand[3];
    end

endmodule

// File: rtl/alu_mux_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between four requesters.
// Drives the operand mux select, pulses alu_start, waits for alu_done and
// returns a one-cycle done pulse to the winner. All outputs are registered.
// Optional build macro ARB_TIMEOUT_EN: bounds the WAIT state to
// TIMEOUT_CYCLES cycles and flags an expired wait on err.
module alu_mux_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             alu_done,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             alu_start,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic             err
);

    // The timeout counter must be able to reach TIMEOUT_CYCLES-1
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_timeout
        $error("alu_mux_arbiter: TIMEOUT_CYCLES out of range for CNT_W");
    end

    state_t           state_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] pick_win;
    logic             pick_any;

    rr_pick_4 u_pick (
        .req (req),
        .ptr (ptr_reg),
        .win (pick_win),
        .any (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg;
`else
    assign err = 1'b0;
`endif

    // Arbitration FSM; sel is only reloaded on a new grant so the mux stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= SEL_W'(NREQ - 1);
            sel       <= '0;
            gnt       <= '0;
            alu_start <= 1'b0;
            done      <= '0;
            busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            alu_start <= 1'b0;
            done      <= '0;
`ifdef ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (pick_any) begin
                        sel       <= pick_win;
                        gnt       <= onehot(pick_win);
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_reg   <= '0;
`endif
                end
                S_WAIT: begin
                    if (alu_done) begin
                        done      <= onehot(sel);
                        gnt       <= '0;
                        state_reg <= S_RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Release anyway so the requester is never stranded
                        done      <= onehot(sel);
                        gnt       <= '0;
                        err       <= 1'b1;
                        state_reg <= S_RELEASE;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
                    ptr_reg   <= sel;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
